// File: rtl/key_sequence_player.sv
// Replays a stored password as one-cycle, one-hot key pulses separated by idle gaps,
// under a start/busy/done handshake with abort. All outputs are registered.
module key_sequence_player #(
  parameter int PASSWORD_LENGTH = 4,
  parameter int NUM_KEYS        = 4,
  parameter int DIGIT_WIDTH     = 2,
  parameter int GAP_CYCLES      = 16
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic                                     start,
  input  logic                                     abort,
  input  logic [PASSWORD_LENGTH*DIGIT_WIDTH-1:0]   digit_sequence,
  output logic [NUM_KEYS-1:0]                      key_pulse,
  output logic                                     busy,
  output logic                                     done,
  output logic [$clog2(PASSWORD_LENGTH+1)-1:0]     digit_index,
  output logic                                     bad_digit
);

  localparam int IDX_W = $clog2(PASSWORD_LENGTH + 1);
  localparam int CNT_W = $clog2(GAP_CYCLES + 1);
  localparam int SEQ_W = PASSWORD_LENGTH * DIGIT_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t               state_reg, state_next;
  logic [NUM_KEYS-1:0]  key_pulse_reg, key_pulse_next;
  logic                 busy_reg, busy_next;
  logic                 done_reg, done_next;
  logic [IDX_W-1:0]     index_reg, index_next;
  logic                 bad_reg, bad_next;
  logic [CNT_W-1:0]     gap_reg, gap_next;
  logic [SEQ_W-1:0]     shadow_reg, shadow_next;
  logic [IDX_W-1:0]     index_inc;

  // Digit table padded to a power of two so any index value selects a defined entry.
  logic [DIGIT_WIDTH-1:0] digits [2**IDX_W];

  generate
    for (genvar gi = 0; gi < 2**IDX_W; gi++) begin : g_digit
      if (gi < PASSWORD_LENGTH) begin : g_used
        assign digits[gi] = shadow_reg[gi*DIGIT_WIDTH +: DIGIT_WIDTH];
      end else begin : g_pad
        assign digits[gi] = '0;
      end
    end
  endgenerate

  // Digits outside the key range decode to no pulse at all.
  function automatic logic [NUM_KEYS-1:0] decode_key(input logic [DIGIT_WIDTH-1:0] d);
    decode_key = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (32'(d) == k) decode_key[k] = 1'b1;
    end
  endfunction

  function automatic logic digit_is_bad(input logic [DIGIT_WIDTH-1:0] d);
    digit_is_bad = (32'(d) >= NUM_KEYS);
  endfunction

  assign index_inc = index_reg + 1'b1;

  always_comb begin
    state_next     = state_reg;
    key_pulse_next = '0;
    busy_next      = busy_reg;
    done_next      = 1'b0;
    index_next     = index_reg;
    bad_next       = bad_reg;
    gap_next       = gap_reg;
    shadow_next    = shadow_reg;

    case (state_reg)
      ST_IDLE: begin
        busy_next  = 1'b0;
        index_next = '0;
        if (start) begin
          // Digit 0 comes straight from the input since the shadow copy lands this edge.
          shadow_next    = digit_sequence;
          bad_next       = 1'b0;
          busy_next      = 1'b1;
          key_pulse_next = decode_key(digit_sequence[DIGIT_WIDTH-1:0]);
          state_next     = ST_PULSE;
        end
      end

      ST_PULSE: begin
        if (abort) begin
          state_next = ST_IDLE;
          busy_next  = 1'b0;
          index_next = '0;
          gap_next   = '0;
        end else begin
          if (digit_is_bad(digits[index_reg])) bad_next = 1'b1;
          gap_next   = CNT_W'(GAP_CYCLES - 1);
          state_next = ST_GAP;
        end
      end

      ST_GAP: begin
        if (abort) begin
          state_next = ST_IDLE;
          busy_next  = 1'b0;
          index_next = '0;
          gap_next   = '0;
        end else if (gap_reg == '0) begin
          if (32'(index_reg) < PASSWORD_LENGTH - 1) begin
            index_next     = index_inc;
            key_pulse_next = decode_key(digits[index_inc]);
            state_next     = ST_PULSE;
          end else begin
            done_next  = 1'b1;
            state_next = ST_DONE;
          end
        end else begin
          gap_next = gap_reg - 1'b1;
        end
      end

      ST_DONE: begin
        state_next = ST_IDLE;
        busy_next  = 1'b0;
        index_next = '0;
      end

      default: begin
        state_next = ST_IDLE;
        busy_next  = 1'b0;
        index_next = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      key_pulse_reg <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      index_reg     <= '0;
      bad_reg       <= 1'b0;
      gap_reg       <= '0;
      shadow_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      key_pulse_reg <= key_pulse_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      index_reg     <= index_next;
      bad_reg       <= bad_next;
      gap_reg       <= gap_next;
      shadow_reg    <= shadow_next;
    end
  end

  assign key_pulse   = key_pulse_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign digit_index = index_reg;
  assign bad_digit   = bad_reg;

endmodule

// File: tb/tb_key_sequence_player.sv
// Directed bench for key_sequence_player: nominal replay, restart rules, abort and bad digits.
// A second instance with three keys exercises out-of-range digits.
module tb_key_sequence_player;

  logic       clk;
  logic       reset;
  logic       start;
  logic       abort;
  logic [7:0] seq;
  logic [3:0] key_pulse;
  logic       busy;
  logic       done;
  logic [2:0] digit_index;
  logic       bad_digit;

  logic       start3;
  logic       abort3;
  logic [7:0] seq3;
  logic [2:0] key_pulse3;
  logic       busy3;
  logic       done3;
  logic [2:0] digit_index3;
  logic       bad_digit3;

  int n_cmp;
  int n_err;

  key_sequence_player dut (
    .clock          (clk),
    .reset          (reset),
    .start          (start),
    .abort          (abort),
    .digit_sequence (seq),
    .key_pulse      (key_pulse),
    .busy           (busy),
    .done           (done),
    .digit_index    (digit_index),
    .bad_digit      (bad_digit)
  );

  key_sequence_player #(.NUM_KEYS(3)) dut3 (
    .clock          (clk),
    .reset          (reset),
    .start          (start3),
    .abort          (abort3),
    .digit_sequence (seq3),
    .key_pulse      (key_pulse3),
    .busy           (busy3),
    .done           (done3),
    .digit_index    (digit_index3),
    .bad_digit      (bad_digit3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two reset edges, then release at a falling edge; the next edge leaves both units idle.
  task automatic do_reset();
    reset  = 1'b1;
    start  = 1'b0;
    abort  = 1'b0;
    start3 = 1'b0;
    abort3 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    start  = 1'b1;
    start3 = 1'b1;
    abort  = 1'b0;
    abort3 = 1'b0;
    seq    = 8'hC9;
    seq3   = 8'h39;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({key_pulse, busy, done, digit_index, bad_digit} !== 10'd0) begin
        n_err++;
        $display("FAIL reset.outputs cyc=%0d got kp=%b busy=%b done=%b idx=%0d bad=%b exp all 0",
                 i, key_pulse, busy, done, digit_index, bad_digit);
      end
      n_cmp++;
      if ({key_pulse3, busy3, done3, digit_index3, bad_digit3} !== 9'd0) begin
        n_err++;
        $display("FAIL reset.outputs3 cyc=%0d got kp=%b busy=%b done=%b idx=%0d bad=%b exp all 0",
                 i, key_pulse3, busy3, done3, digit_index3, bad_digit3);
      end
    end
    reset  = 1'b0;
    start  = 1'b0;
    start3 = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n_cmp++;
      if (key_pulse !== 4'b0000 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL reset.quiet cyc=%0d got kp=%b busy=%b exp kp=0000 busy=0", i, key_pulse, busy);
      end
    end
    $display("test_reset: done, %0d compared so far", n_cmp);
  endtask

  // Start at cycle 0 with C9 (digits 1,2,0,3); sequence cleared at 10; starts at 30 and 69
  // must be ignored; start at 70 restarts with the now-zero sequence.
  task automatic test_nominal();
    logic [3:0] exp_kp;
    logic       exp_busy;
    logic       exp_done;
    logic [2:0] exp_idx;
    do_reset();
    seq = 8'hC9;
    @(negedge clk);
    start = 1'b1;
    for (int t = 1; t <= 72; t++) begin
      @(negedge clk);
      case (t)
        1:       exp_kp = 4'b0010;
        18:      exp_kp = 4'b0100;
        35:      exp_kp = 4'b0001;
        52:      exp_kp = 4'b1000;
        71:      exp_kp = 4'b0001;
        default: exp_kp = 4'b0000;
      endcase
      exp_busy = (t <= 69) || (t >= 71);
      exp_done = (t == 69);
      exp_idx  = (t <= 68) ? 3'((t - 1) / 17) : 3'd0;
      n_cmp++;
      if (key_pulse !== exp_kp) begin
        n_err++;
        $display("FAIL nominal.key_pulse t=%0d got=%b exp=%b", t, key_pulse, exp_kp);
      end
      n_cmp++;
      if (busy !== exp_busy) begin
        n_err++;
        $display("FAIL nominal.busy t=%0d got=%b exp=%b", t, busy, exp_busy);
      end
      n_cmp++;
      if (done !== exp_done) begin
        n_err++;
        $display("FAIL nominal.done t=%0d got=%b exp=%b", t, done, exp_done);
      end
      n_cmp++;
      if (bad_digit !== 1'b0) begin
        n_err++;
        $display("FAIL nominal.bad_digit t=%0d got=%b exp=0", t, bad_digit);
      end
      if (t != 69) begin
        n_cmp++;
        if (digit_index !== exp_idx) begin
          n_err++;
          $display("FAIL nominal.digit_index t=%0d got=%0d exp=%0d", t, digit_index, exp_idx);
        end
      end
      if (t == 10) seq = 8'h00;
      start = (t == 30) || (t == 69) || (t == 70);
    end
    start = 1'b0;
    $display("test_nominal: done, %0d compared so far", n_cmp);
  endtask

  // Abort at cycle 20 (mid-gap), restart at 25: new schedule begins at 26.
  task automatic test_abort();
    logic [3:0] exp_kp;
    logic       exp_busy;
    logic [2:0] exp_idx;
    do_reset();
    seq = 8'hC9;
    @(negedge clk);
    start = 1'b1;
    for (int t = 1; t <= 45; t++) begin
      @(negedge clk);
      case (t)
        1:       exp_kp = 4'b0010;
        18:      exp_kp = 4'b0100;
        26:      exp_kp = 4'b0010;
        43:      exp_kp = 4'b0100;
        default: exp_kp = 4'b0000;
      endcase
      exp_busy = (t <= 20) || (t >= 26);
      if (t <= 20)      exp_idx = 3'((t - 1) / 17);
      else if (t <= 25) exp_idx = 3'd0;
      else              exp_idx = 3'((t - 26) / 17);
      n_cmp++;
      if (key_pulse !== exp_kp) begin
        n_err++;
        $display("FAIL abort.key_pulse t=%0d got=%b exp=%b", t, key_pulse, exp_kp);
      end
      n_cmp++;
      if (busy !== exp_busy) begin
        n_err++;
        $display("FAIL abort.busy t=%0d got=%b exp=%b", t, busy, exp_busy);
      end
      n_cmp++;
      if (done !== 1'b0) begin
        n_err++;
        $display("FAIL abort.done t=%0d got=%b exp=0", t, done);
      end
      n_cmp++;
      if (digit_index !== exp_idx) begin
        n_err++;
        $display("FAIL abort.digit_index t=%0d got=%0d exp=%0d", t, digit_index, exp_idx);
      end
      start = (t == 25);
      abort = (t == 20);
    end
    start = 1'b0;
    abort = 1'b0;
    $display("test_abort: done, %0d compared so far", n_cmp);
  endtask

  // abort alone in IDLE does nothing; start together with abort in IDLE still starts.
  task automatic test_start_abort_idle();
    do_reset();
    seq = 8'hC9;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || key_pulse !== 4'b0000) begin
      n_err++;
      $display("FAIL idle_abort.outputs got busy=%b kp=%b exp busy=0 kp=0000", busy, key_pulse);
    end
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    n_cmp++;
    if (key_pulse !== 4'b0010 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL start_abort.first_pulse got kp=%b busy=%b exp kp=0010 busy=1", key_pulse, busy);
    end
    $display("test_start_abort_idle: done, %0d compared so far", n_cmp);
  endtask

  // Three keys, sequence 39 (digits 1,2,3,0): slot 2 is out of range.
  task automatic test_bad_digit();
    logic [2:0] exp_kp;
    logic       exp_bad;
    do_reset();
    seq3 = 8'h39;
    @(negedge clk);
    start3 = 1'b1;
    for (int t = 1; t <= 71; t++) begin
      @(negedge clk);
      case (t)
        1:       exp_kp = 3'b010;
        18:      exp_kp = 3'b100;
        52:      exp_kp = 3'b001;
        71:      exp_kp = 3'b010;
        default: exp_kp = 3'b000;
      endcase
      exp_bad = (t >= 36) && (t <= 70);
      n_cmp++;
      if (key_pulse3 !== exp_kp) begin
        n_err++;
        $display("FAIL bad.key_pulse t=%0d got=%b exp=%b", t, key_pulse3, exp_kp);
      end
      n_cmp++;
      if (bad_digit3 !== exp_bad) begin
        n_err++;
        $display("FAIL bad.bad_digit t=%0d got=%b exp=%b", t, bad_digit3, exp_bad);
      end
      n_cmp++;
      if (done3 !== (t == 69)) begin
        n_err++;
        $display("FAIL bad.done t=%0d got=%b exp=%b", t, done3, (t == 69));
      end
      start3 = (t == 70);
    end
    start3 = 1'b0;
    $display("test_bad_digit: done, %0d compared so far", n_cmp);
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    reset  = 1'b1;
    start  = 1'b0;
    abort  = 1'b0;
    seq    = 8'h00;
    start3 = 1'b0;
    abort3 = 1'b0;
    seq3   = 8'h00;
    test_reset();
    test_nominal();
    test_abort();
    test_start_abort_idle();
    test_bad_digit();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
